sap_microcode_sequencer: RTL and testbench
==========================================

// Module: sap_microcode_sequencer
// PURPOSE
// Parametrised microcoded control sequencer, successor to the fixed 3-instruction SAP-1 controller.
// Decodes the full SAP-1 set, including STA, LDI, SUB, JMP, JC, JZ and HLT, into a registered control word.
// Uses variable-length instructions with early termination and conditional jumps on datapath flags.
// Drives the control bus of the SAP datapath: PC, MAR, RAM, IR, A, B, ALU, OUT and flag registers.
// PARAMETERS
// OPC_W   4  opcode width; opcodes >= 16 decode as NOP
// STEP_W  3  microstep counter width; max 2**STEP_W steps per instruction
// PORTS
// clk          in   1       system clock; all state updates on falling edge (offset from datapath)
// reset        in   1       synchronous, active-high
// instruction  in   OPC_W   opcode field from instruction register
// carry_flag   in   1       latched ALU carry from flag register
// zero_flag    in   1       latched ALU zero from flag register
// step_en      in   1       single-step advance; present only with SAP_SINGLE_STEP_EN
// CBUS_OUT     out  16      registered control word
// micro_step   out  STEP_W  current microstep (T-state)
// halted       out  1       sticky halt status
// BEHAVIOUR
// - CBUS bits: 15 HALT,14 MI,13 RI,12 RO,11 IO,10 II,9 AI,8 AO,7 SMO,6 SUB,5 BI,4 OI,3 CE,2 CO,1 J,0 FI.
// - Reset (sampled at negedge): CBUS_OUT=0, micro_step=0, halted=0. Reset aborts any instruction mid-flight.
// - Each negedge: CBUS_OUT <= decode(instruction, micro_step, flags).
//   micro_step <= last ? 0 : micro_step+1.
// - Decode is combinational and yields {cw, last}. The registered word is valid for the following rising edge.
// - T0: MI|CO. T1: RO|II|CE. Fetch is common to all opcodes; neither step is ever last.
// - T2+ by opcode (the word marked * is last):
//   NOP 0: T2 0*.
//   LDA 1: T2 IO|MI; T3 RO|AI*.
//   ADD 2: T2 IO|MI; T3 RO|BI; T4 SMO|AI|FI*.
//   SUB 3: T2 IO|MI; T3 RO|BI; T4 SMO|SUB|AI|FI*.
//   STA 4: T2 IO|MI; T3 AO|RI*.
//   LDI 5: T2 IO|AI*.
//   JMP 6: T2 IO|J*.
//   JC 7: T2 carry_flag ? IO|J : 0 *.
//   JZ 8: T2 zero_flag ? IO|J : 0 *.
//   OUT 14: T2 AO|OI*.
//   HLT 15: T2 HALT*.
//   Opcodes 9-13 and >=16 decode as NOP.
// - Instruction length is 3, 4 or 5 steps. The step after a last step is always T0, with no bubble.
// - Flags are sampled in the same negedge that produces T2. A flag change at any other step has no effect.
// - Wrap guard: if micro_step == 2**STEP_W-1, force last=1. With STEP_W < 3, ADD/SUB are truncated (illegal config).
// - Halt: on issuing HALT, halted <= 1. While halted, CBUS_OUT holds HALT only and micro_step holds.
//   Only reset clears halt; halted and reset asserted together gives reset priority.
// - instruction is ignored during T0/T1; the IR is loaded by the datapath at the T1 rising edge.
// CONFIGURATION
// - SAP_SINGLE_STEP_EN defined: step_en port exists.
//   When step_en=0 at a negedge, micro_step holds and CBUS_OUT <= 0 (bubble, so CE/J do not repeat).
//   When step_en=1, the sequencer advances normally. Halt and reset behave as without the macro.
// - SAP_SINGLE_STEP_EN undefined: no step_en port; the sequencer advances every negedge.
// TESTING
// - Reset, then release with instruction=1 (LDA).
//   CBUS sequence 0x4004, 0x1408, 0x4800, 0x1200, then 0x4004 again; micro_step 0,1,2,3,0.
// - ADD (2): T4 word 0x0281. SUB (3): T4 word 0x02C1. Both 5 steps, then T0.
// - JC (7) with carry_flag=1: T2 word 0x0802. With carry_flag=0: T2 word 0x0000.
//   Both return to T0 next. Repeat with JZ (8) on zero_flag.
// - HLT (15): T2 CBUS=0x8000, halted=1, held for 10 cycles.
//   Then reset high for 1 negedge gives CBUS=0, micro_step=0, halted=0.
// - Reset asserted at T3 of ADD: next CBUS=0, micro_step=0. After release, fetch restarts at 0x4004.
// - SAP_SINGLE_STEP_EN with step_en held 0 for 3 cycles at T1: CBUS=0, micro_step=1 held.
//   On step_en=1, CBUS=0x1408 is issued exactly once.

Source files
------------

// File: rtl/sap_microcode_sequencer.sv
// sap_microcode_sequencer: microcoded SAP-1 control sequencer with registered control word, updated on falling clock edges.
// Define SAP_SINGLE_STEP_EN to add the step_en single-step input.
module sap_microcode_sequencer #(
  parameter int OPC_W  = 4,
  parameter int STEP_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [OPC_W-1:0]  instruction,
  input  logic              carry_flag,
  input  logic              zero_flag,
`ifdef SAP_SINGLE_STEP_EN
  input  logic              step_en,
`endif
  output logic [15:0]       CBUS_OUT,
  output logic [STEP_W-1:0] micro_step,
  output logic              halted
);
  localparam logic [15:0] HALT = 16'h8000, MI = 16'h4000, RI = 16'h2000, RO = 16'h1000;
  localparam logic [15:0] IO = 16'h0800, II = 16'h0400, AI = 16'h0200, AO = 16'h0100;
  localparam logic [15:0] SMO = 16'h0080, SUB = 16'h0040, BI = 16'h0020, OI = 16'h0010;
  localparam logic [15:0] CE = 16'h0008, CO = 16'h0004, J = 16'h0002, FI = 16'h0001;
  localparam logic [STEP_W-1:0] T0 = '0, T1 = STEP_W'(1), T2 = STEP_W'(2), T3 = STEP_W'(3);
  logic [OPC_W+3:0] ins_x;
  logic [3:0]       op;
  logic [15:0]      cw;
  logic             last;
  assign ins_x = {4'd0, instruction};
  assign op    = (ins_x >> 4) != '0 ? 4'd0 : ins_x[3:0];
  always_comb begin
    cw   = '0;
    last = 1'b0;
    case (op)
      4'd1:       {cw, last} = micro_step == T2 ? {IO | MI, 1'b0} : {RO | AI, 1'b1};
      4'd2, 4'd3: {cw, last} = micro_step == T2 ? {IO | MI, 1'b0} :
                               micro_step == T3 ? {RO | BI, 1'b0} :
                               {SMO | AI | FI | (op == 4'd3 ? SUB : 16'h0), 1'b1};
      4'd4:       {cw, last} = micro_step == T2 ? {IO | MI, 1'b0} : {AO | RI, 1'b1};
      4'd5:       {cw, last} = {IO | AI, 1'b1};
      4'd6:       {cw, last} = {IO | J, 1'b1};
      4'd7:       {cw, last} = {carry_flag ? IO | J : 16'h0, 1'b1};
      4'd8:       {cw, last} = {zero_flag ? IO | J : 16'h0, 1'b1};
      4'd14:      {cw, last} = {AO | OI, 1'b1};
      4'd15:      {cw, last} = {HALT, 1'b1};
      default:    {cw, last} = {16'h0, 1'b1};
    endcase
    // Fetch overrides the opcode: the IR is not valid until after T1.
    if (micro_step == T0) {cw, last} = {MI | CO, 1'b0};
    if (micro_step == T1) {cw, last} = {RO | II | CE, 1'b0};
    if (micro_step == '1) last = 1'b1;
  end
  always_ff @(negedge clk) begin
    if (reset) begin
      CBUS_OUT   <= '0;
      micro_step <= '0;
      halted     <= 1'b0;
    end else if (halted) begin
      CBUS_OUT   <= HALT;
`ifdef SAP_SINGLE_STEP_EN
    end else if (!step_en) begin
      CBUS_OUT   <= '0;
`endif
    end else begin
      CBUS_OUT   <= cw;
      micro_step <= last ? '0 : micro_step + 1'b1;
      halted     <= cw[15];
    end
  end
endmodule

// File: tb/tb_sap_microcode_sequencer.sv
// tb_sap_microcode_sequencer: directed and random checks of the sequencer against a queue-based instruction model.
module tb_sap_microcode_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  instruction = '0;
  logic        carry_flag = 1'b0;
  logic        zero_flag = 1'b0;
  logic        step_en = 1'b1;
  logic [15:0] CBUS_OUT;
  logic [2:0]  micro_step;
  logic        halted;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] m_cbus = '0;
  int          m_step = 0;
  bit          m_halt = 1'b0;
  logic [15:0] q[$];
  sap_microcode_sequencer #(.OPC_W(4), .STEP_W(3)) dut (
    .clk(clk),
    .reset(reset),
    .instruction(instruction),
    .carry_flag(carry_flag),
    .zero_flag(zero_flag),
`ifdef SAP_SINGLE_STEP_EN
    .step_en(step_en),
`endif
    .CBUS_OUT(CBUS_OUT),
    .micro_step(micro_step),
    .halted(halted)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic void load_body(int op, bit c, bit z);
    case (op)
      1:       q = {16'h4800, 16'h1200};
      2:       q = {16'h4800, 16'h1020, 16'h0281};
      3:       q = {16'h4800, 16'h1020, 16'h02C1};
      4:       q = {16'h4800, 16'h2100};
      5:       q = {16'h0A00};
      6:       q = {16'h0802};
      7:       q = {c ? 16'h0802 : 16'h0000};
      8:       q = {z ? 16'h0802 : 16'h0000};
      14:      q = {16'h0110};
      15:      q = {16'h8000};
      default: q = {16'h0000};
    endcase
  endfunction
  task automatic tick(input bit r, input int op, input bit c, input bit z, input bit en);
    reset = r;
    instruction = op[3:0];
    carry_flag = c;
    zero_flag = z;
    step_en = en;
    if (r) begin
      m_cbus = '0; m_step = 0; m_halt = 1'b0; q.delete();
    end else if (m_halt) begin
      m_cbus = 16'h8000;
    end else if (!en) begin
      m_cbus = '0;
    end else if (m_step == 0) begin
      m_cbus = 16'h4004; m_step = 1;
    end else if (m_step == 1) begin
      m_cbus = 16'h1408; m_step = 2;
    end else begin
      if (m_step == 2) load_body(op, c, z);
      m_cbus = q.pop_front();
      m_step = q.size() == 0 ? 0 : m_step + 1;
      m_halt = m_cbus[15];
    end
    @(negedge clk);
    @(posedge clk);
    check("cbus", CBUS_OUT, m_cbus);
    check("step", 16'(micro_step), 16'(m_step));
    check("halted", 16'(halted), 16'(m_halt));
  endtask
  initial begin
    logic [15:0] lda_w[5];
    int          lda_s[5];
    int          cur_op;
    bit          r, en, c;
    lda_w = '{16'h4004, 16'h1408, 16'h4800, 16'h1200, 16'h4004};
    lda_s = '{1, 2, 3, 0, 1};
    @(posedge clk);
    tick(1, 1, 0, 0, 1);
    check("rst_cbus", CBUS_OUT, 16'h0);
    check("rst_step", 16'(micro_step), 16'h0);
    check("rst_halt", 16'(halted), 16'h0);
    for (int i = 0; i < 5; i++) begin
      tick(0, 1, 0, 0, 1);
      check("lda_cbus", CBUS_OUT, lda_w[i]);
      check("lda_step", 16'(micro_step), 16'(lda_s[i]));
    end
    for (int op = 2; op <= 3; op++) begin
      tick(1, op, 0, 0, 1);
      for (int i = 0; i < 5; i++) tick(0, op, 0, 0, 1);
      check("alu_t4", CBUS_OUT, op == 2 ? 16'h0281 : 16'h02C1);
      check("alu_step", 16'(micro_step), 16'h0);
      tick(0, op, 0, 0, 1);
      check("alu_next", CBUS_OUT, 16'h4004);
    end
    for (int op = 7; op <= 8; op++) begin
      for (int f = 0; f < 2; f++) begin
        tick(1, op, 0, 0, 1);
        tick(0, op, 0, 0, 1);
        tick(0, op, 0, 0, 1);
        tick(0, op, op == 7 ? f[0] : 1'b0, op == 8 ? f[0] : 1'b0, 1);
        check("jump_t2", CBUS_OUT, f == 1 ? 16'h0802 : 16'h0000);
        tick(0, op, ~f[0], ~f[0], 1);
        check("jump_next", CBUS_OUT, 16'h4004);
      end
    end
    tick(1, 15, 0, 0, 1);
    for (int i = 0; i < 3; i++) tick(0, 15, 0, 0, 1);
    check("hlt_cbus", CBUS_OUT, 16'h8000);
    check("hlt_flag", 16'(halted), 16'h1);
    for (int i = 0; i < 10; i++) begin
      tick(0, i % 16, 1, 1, 1);
      check("hlt_hold", CBUS_OUT, 16'h8000);
    end
    tick(1, 0, 0, 0, 1);
    check("hlt_rst_cbus", CBUS_OUT, 16'h0);
    check("hlt_rst_halt", 16'(halted), 16'h0);
    for (int i = 0; i < 3; i++) tick(0, 2, 0, 0, 1);
    check("mid_step", 16'(micro_step), 16'h3);
    tick(1, 2, 0, 0, 1);
    check("mid_rst_cbus", CBUS_OUT, 16'h0);
    check("mid_rst_step", 16'(micro_step), 16'h0);
    tick(0, 2, 0, 0, 1);
    check("mid_refetch", CBUS_OUT, 16'h4004);
`ifdef SAP_SINGLE_STEP_EN
    tick(1, 1, 0, 0, 1);
    tick(0, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, 0, 0, 0);
      check("ss_bubble", CBUS_OUT, 16'h0);
      check("ss_hold", 16'(micro_step), 16'h1);
    end
    tick(0, 1, 0, 0, 1);
    check("ss_step", CBUS_OUT, 16'h1408);
    tick(0, 1, 0, 0, 0);
    check("ss_once", CBUS_OUT, 16'h0);
`endif
    cur_op = 0;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom % 64) == 0;
      if (m_step < 2) begin
        cur_op = $urandom % 16;
        if (cur_op == 15 && ($urandom % 4) != 0) cur_op = 0;
      end
      c = $urandom % 2;
`ifdef SAP_SINGLE_STEP_EN
      en = ($urandom % 4) != 0;
`else
      en = 1'b1;
`endif
      tick(r, cur_op, c, $urandom % 2, en);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
